// File: rtl/bus_arbiter_4_pkg.sv
`default_nettype none
//============================================================================
// Module   : bus_arbiter_4_pkg
// Purpose  : Shared constants, state encoding and helpers for the 4-way
//            round-robin bus arbiter and its pick logic.
// Revision : 1.0 - initial release
//============================================================================
package bus_arbiter_4_pkg;

    // Requester indices as seen on the shared 4-channel mux select
    localparam logic [1:0] REQ_IF  = 2'd0;
    localparam logic [1:0] REQ_MEM = 2'd1;
    localparam logic [1:0] REQ_UNC = 2'd2;
    localparam logic [1:0] REQ_DBG = 2'd3;

    // Default watchdog limit and hold-counter width
    localparam int HOLD_MAX_DEFAULT = 255;
    localparam int CNT_W_DEFAULT    = 8;

    // Arbiter state: either nobody owns the resource or one requester does
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Convert a requester index into its one-hot grant vector
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_4_rr_pick4.sv
`default_nettype none
//============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin picker. Searches the request mask
//            starting one position after the last pointer, wrapping mod 4,
//            and returns the first asserted index.
// Revision : 1.0 - initial release
//============================================================================
module rr_pick4
    import bus_arbiter_4_pkg::*;
(
    input  logic [3:0] i_req_mask,
    input  logic [1:0] i_last,
    output logic       o_found,
    output logic [1:0] o_winner
);

    // Candidate k (0..3) is the index last+1+k; candidate 0 has top priority
    logic [1:0] w_cand_idx [4];
    logic [3:0] w_cand_hit;
    logic [1:0] w_winner;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand_idx[gi] = i_last + 2'(gi + 1);
            assign w_cand_hit[gi] = i_req_mask[w_cand_idx[gi]];
        end
    endgenerate

    // Priority select: walk from lowest priority up so the nearest hit wins
    always_comb begin
        w_winner = i_last;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                w_winner = w_cand_idx[k];
            end
        end
    end

    assign o_found  = |w_cand_hit;
    assign o_winner = w_winner;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_4.sv
`default_nettype none
//============================================================================
// Module   : bus_arbiter_4
// Purpose  : Round-robin arbiter sharing one resource between four
//            requesters. Grant is held until done; a hold-counter watchdog
//            revokes a hung owner and demotes it to lowest priority.
//            All outputs are registered.
// Revision : 1.0 - initial release
//============================================================================
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    // Reject watchdog limits the hold counter cannot reach
    generate
        if ((HOLD_MAX < 1) || (HOLD_MAX > (2 ** CNT_W) - 1)) begin : g_bad_hold_max
            $error("bus_arbiter_4: HOLD_MAX out of range for CNT_W");
        end
    endgenerate

    // Counter value seen during the last permitted owned cycle
    localparam logic [CNT_W-1:0] c_wd_limit = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    arb_state_e       r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_timeout;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_owning;
    logic [3:0]       w_owner_oh;
    logic [3:0]       w_pick_mask;
    logic [1:0]       w_pick_last;
    logic             w_done_evt;
    logic             w_wd_evt;
    logic             w_release;
    logic             w_found;
    logic [1:0]       w_winner;

    // While owning, the current owner is masked out and the search starts
    // after it, since on any release last becomes the owner's index.
    assign w_owning    = (r_state == ST_OWN);
    assign w_owner_oh  = onehot4(r_sel);
    assign w_pick_mask = w_owning ? (req & ~w_owner_oh) : req;
    assign w_pick_last = w_owning ? r_sel : r_last;

    // done wins over watchdog expiry in the same cycle, so no timeout then
    assign w_done_evt  = w_owning & done;
    assign w_wd_evt    = w_owning & ~done & (r_cnt == c_wd_limit);
    assign w_release   = w_done_evt | w_wd_evt;

    rr_pick4 u_pick (
        .i_req_mask (w_pick_mask),
        .i_last     (w_pick_last),
        .o_found    (w_found),
        .o_winner   (w_winner)
    );

    // Arbiter FSM with registered grant/sel/busy/timeout and hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= REQ_IF;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= REQ_DBG;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // done arriving here has no owner to release and is ignored
                    if (w_found) begin
                        r_state <= ST_OWN;
                        r_grant <= onehot4(w_winner);
                        r_sel   <= w_winner;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_last    <= r_sel;
                        r_timeout <= w_wd_evt;
                        if (w_found) begin
                            // direct handoff, no idle bubble between owners
                            r_grant <= onehot4(w_winner);
                            r_sel   <= w_winner;
                            r_cnt   <= '0;
                        end else begin
                            // sel keeps the last owner's index while idle
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
//============================================================================
// Module   : tb_bus_arbiter_4
// Purpose  : Self-checking bench for bus_arbiter_4 (watchdog limit 4).
//            Each scenario pushes expected outputs as it drives inputs and
//            pops/compares them once the clock edge has produced outputs.
// Revision : 1.0 - initial release
//============================================================================
module tb_bus_arbiter_4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        exp_t       exp;
    } step_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bus_arbiter_4 #(
        .HOLD_MAX (4),
        .CNT_W    (8)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    function automatic step_t mk(input logic [3:0] r, input logic d,
                                 input logic [3:0] g, input logic [1:0] s,
                                 input logic b, input logic t);
        mk = {r, d, g, s, b, t};
    endfunction

    task automatic apply_reset();
        req   = 4'b0000;
        done  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        @(negedge clk);
        sb_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, sel, busy, timeout} !== e)
            $display("FAIL reset_hold: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                     grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
        else
            n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, sel, busy, timeout} !== e)
            $display("FAIL reset_idle: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                     grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
        else
            n_pass++;
    endtask

    // Single grant, release to idle, done ignored while idle
    task automatic test_basic();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        apply_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({grant, sel, busy, timeout} !== e)
                $display("FAIL basic[%0d]: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                         i, grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
            else
                n_pass++;
        end
    endtask

    // All four requesting, done every 4th owned cycle (coincides with the
    // watchdog limit of 4, so it must stay a normal done with no timeout)
    task automatic test_rotation();
        step_t      tbl[$];
        exp_t       e;
        logic [1:0] nxt;
        tbl.push_back(mk(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        for (int o = 0; o < 4; o++) begin
            for (int j = 0; j < 3; j++)
                tbl.push_back(mk(4'b1111, 1'b0, 4'b0001 << o, 2'(o), 1'b1, 1'b0));
            nxt = 2'(o + 1);
            tbl.push_back(mk(4'b1111, 1'b1, 4'b0001 << nxt, nxt, 1'b1, 1'b0));
        end
        apply_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({grant, sel, busy, timeout} !== e)
                $display("FAIL rotation[%0d]: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                         i, grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
            else
                n_pass++;
        end
    endtask

    // Owner's own still-high request is excluded at done, then regranted
    task automatic test_owner_exclusion();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        apply_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({grant, sel, busy, timeout} !== e)
                $display("FAIL owner_excl[%0d]: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                         i, grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
            else
                n_pass++;
        end
    endtask

    // Hung owner revoked after 4 owned cycles, demoted, then a watchdog
    // release into idle after the owner dropped req without done
    task automatic test_watchdog();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        apply_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({grant, sel, busy, timeout} !== e)
                $display("FAIL watchdog[%0d]: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                         i, grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
            else
                n_pass++;
        end
    endtask

    // Reset raised between edges while owning clears outputs immediately
    task automatic test_async_reset();
        exp_t e;
        apply_reset();
        req = 4'b0100;
        sb_q.push_back({4'b0100, 2'd2, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, sel, busy, timeout} !== e)
            $display("FAIL async_own: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                     grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
        else
            n_pass++;
        #2;
        reset = 1'b1;
        sb_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, sel, busy, timeout} !== e)
            $display("FAIL async_clear: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                     grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
        else
            n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1000;
        sb_q.push_back({4'b1000, 2'd3, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, sel, busy, timeout} !== e)
            $display("FAIL async_regrant: grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                     grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
        else
            n_pass++;
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_owner_exclusion();
        test_watchdog();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not complete, passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
